// File: rtl/counter_cmd_arbiter_if.sv
// rtl/counter_cmd_arbiter_if.sv - command/response bundle between requesters and the shared counter
interface counter_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_value;
  logic                     rsp_wrap;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_value, rsp_wrap
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_value, rsp_wrap
  );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// rtl/counter_cmd_arbiter.sv - round-robin shared up/down counter with response channel and sticky alarm
module counter_cmd_arbiter #(
  parameter int               NUM_REQ     = 4,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] WATCH_VALUE = WIDTH'(5),
  parameter int               IDW         = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  counter_cmd_arbiter_if.slave bus,
  output logic [WIDTH-1:0]   value,
  output logic               alarm
);

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDW-1:0]     rr_ptr;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [IDW-1:0]     id_q;

  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     grant_ptr_next;
  logic [1:0]         grant_op;
  logic [WIDTH-1:0]   grant_data;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [WIDTH-1:0]   value_next;
  logic               wrap_next;

  // Search starts at rr_ptr so the most recent winner gets lowest priority next time.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    grant_op    = '0;
    grant_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
        grant_op    = bus.req_op[2*idx +: 2];
        grant_data  = bus.req_data[WIDTH*idx +: WIDTH];
      end
    end
    grant_ptr_next = IDW'((int'(grant_id) + 1) % NUM_REQ);
  end

  always_comb begin
    value_next = value;
    wrap_next  = 1'b0;
    case (op_q)
      OP_UP: begin
        value_next = value + WIDTH'(1);
        wrap_next  = (value == '1);
      end
      OP_DOWN: begin
        value_next = value - WIDTH'(1);
        wrap_next  = (value == '0);
      end
      OP_LOAD:  value_next = data_q;
      OP_CLEAR: value_next = '0;
      default:  value_next = value;
    endcase
  end

  always_comb begin
    state_next  = state;
    req_ready_c = '0;
    case (state)
      IDLE: begin
        if (grant_found && !reset) begin
          req_ready_c[grant_id] = 1'b1;
          state_next            = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state == RESP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      op_q          <= '0;
      data_q        <= '0;
      id_q          <= '0;
      value         <= '0;
      alarm         <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_value <= '0;
      bus.rsp_wrap  <= 1'b0;
    end else begin
      state <= state_next;
      alarm <= alarm | (value == WATCH_VALUE);
      if (state == IDLE && grant_found) begin
        op_q   <= grant_op;
        data_q <= grant_data;
        id_q   <= grant_id;
        rr_ptr <= grant_ptr_next;
      end
      if (state == EXEC) begin
        value         <= value_next;
        bus.rsp_value <= value_next;
        bus.rsp_id    <= id_q;
        bus.rsp_wrap  <= wrap_next;
      end
    end
  end

endmodule
